l2_tag_ctrl: RTL and testbench
==============================

L2_TAG_CTRL -- requirements
Module: l2_tag_ctrl

Interface
REQ-001 SHALL have parameter-free ports; clock clk, reset rst, synchronous, active-high.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 req_valid / req_ready  input / output  1 / 1  lookup request handshake.
REQ-005 req_addr  input  32  physical address: tag = [31:14], index = [13:5].
REQ-006 req_write  input  1  access marks line dirty.
REQ-007 l2_block0_re..l2_block3_re, l2_block0_we..l2_block3_we  output  1 each  per-way tag RAM read/write strobes.
REQ-008 l2_index  output  9 / l2_tag_wd  output  18 / l2_dirty_wd  output  1  tag RAM address and write data.
REQ-009 l2_tag0_rd..l2_tag3_rd  input  18 each / l2_dirty0..l2_dirty3  input  1 each / plru  input  3 / l2_complete  input  1  tag RAM returns.
REQ-010 resp_valid  output  1 / resp_hit  output  1 / resp_way  output  2 / resp_victim_dirty  output  1 / resp_victim_tag  output  18  one-cycle result.
REQ-011 wb_req  output  1 / wb_done  input  1  victim write-back handshake (Configuration only).

Function
REQ-012 States: IDLE, READ, CMP, WB_WAIT, WRITE, RESP.
REQ-013 IDLE: req_ready = 1; on req_valid, latch addr and write flag, go to READ; req_ready = 0 in all other states.
REQ-014 READ: assert all four re strobes for exactly one cycle with l2_index = latched index; go to CMP.
REQ-015 CMP: RAM outputs valid; hit_n = (l2_tagN_rd == latched tag); hit = OR of hit_n; multiple hits resolve to lowest way.
REQ-016 Victim on miss: plru[0]=1 -> plru[2] ? way3 : way2; plru[0]=0 -> plru[1] ? way1 : way0.
REQ-017 Selected way = hit way on hit, victim on miss; register way, hit, dirty of selected way, tag of selected way.
REQ-018 CMP -> WB_WAIT on miss with dirty victim (macro defined); otherwise CMP -> WRITE.
REQ-019 WRITE: hold we of selected way only, l2_tag_wd = latched tag; l2_dirty_wd = (hit & old dirty) | req_write; on hit this rewrite refreshes PLRU.
REQ-020 WRITE exits to RESP in the cycle l2_complete = 1 is sampled; we deasserted in RESP; l2_complete is ignored outside WRITE.
REQ-021 RESP: resp_valid = 1 for one cycle with resp_hit, resp_way, resp_victim_dirty (0 on hit), resp_victim_tag (old tag of selected way); go to IDLE.
REQ-022 At most one we and never re with we in the same cycle; l2_index constant from READ through RESP.
REQ-023 Minimum latency: accept at cycle 0, response at cycle 4 + extra WRITE cycles (l2_complete arrives after 1-2 we cycles).
REQ-024 resp_* other than resp_valid hold last value until next RESP.

Reset
REQ-025 rst SHALL force IDLE regardless of state, including mid-WRITE or WB_WAIT; request aborted, no response.
REQ-026 Reset values: req_ready=1 (after reset), all re/we=0, wb_req=0, resp_valid=0, resp_hit=0, resp_way=0, resp_victim_dirty=0, resp_victim_tag=0, l2_index=0, l2_tag_wd=0, l2_dirty_wd=0.

Configuration
REQ-027 Macro L2_VICTIM_WB_EN: defined -> WB_WAIT enabled: wb_req=1 in WB_WAIT until wb_done=1 sampled, then WRITE; wb_done outside WB_WAIT ignored.
REQ-028 Not defined -> WB_WAIT unreachable, wb_req tied 0, wb_done unused; dirty victim still reported via resp_victim_dirty.

Verification
REQ-029 Hit: way2 tag = 0x2A5A5 at index 0x1F3, read addr {0x2A5A5,0x1F3,5'h0} -> resp_hit=1, resp_way=2, way2 rewritten with dirty unchanged.
REQ-030 Miss with plru=3'b001, way2 clean -> victim way2, resp_hit=0, resp_way=2, new tag written, dirty_wd=req_write.
REQ-031 Miss with plru=3'b000, way0 dirty, macro defined -> wb_req high until wb_done pulse after 3 cycles, then write; resp_victim_dirty=1; macro undefined -> no wb_req.
REQ-032 Duplicate tag in ways 1 and 3 -> resp_way=1.
REQ-033 l2_complete delayed 1 vs 2 cycles -> we held exactly until complete sampled; response cycle 5 vs 6.
REQ-034 rst asserted during WRITE -> next cycle all we=0, req_ready=1, no resp_valid.

Source files
------------

// File: rtl/l2_tag_ctrl_if.sv
// L2 tag controller bus bundle: lookup request, 4-way tag RAM port,
// one-cycle response and victim write-back handshake.
// slave  = controller side, master = requester / tag RAM / write-back side.
interface l2_tag_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        req_write;

   logic        l2_block0_re;
   logic        l2_block1_re;
   logic        l2_block2_re;
   logic        l2_block3_re;
   logic        l2_block0_we;
   logic        l2_block1_we;
   logic        l2_block2_we;
   logic        l2_block3_we;
   logic [8:0]  l2_index;
   logic [17:0] l2_tag_wd;
   logic        l2_dirty_wd;

   logic [17:0] l2_tag0_rd;
   logic [17:0] l2_tag1_rd;
   logic [17:0] l2_tag2_rd;
   logic [17:0] l2_tag3_rd;
   logic        l2_dirty0;
   logic        l2_dirty1;
   logic        l2_dirty2;
   logic        l2_dirty3;
   logic [2:0]  plru;
   logic        l2_complete;

   logic        resp_valid;
   logic        resp_hit;
   logic [1:0]  resp_way;
   logic        resp_victim_dirty;
   logic [17:0] resp_victim_tag;

   logic        wb_req;
   logic        wb_done;

   modport slave (
      input  req_valid, req_addr, req_write,
      output req_ready,
      output l2_block0_re, l2_block1_re, l2_block2_re, l2_block3_re,
      output l2_block0_we, l2_block1_we, l2_block2_we, l2_block3_we,
      output l2_index, l2_tag_wd, l2_dirty_wd,
      input  l2_tag0_rd, l2_tag1_rd, l2_tag2_rd, l2_tag3_rd,
      input  l2_dirty0, l2_dirty1, l2_dirty2, l2_dirty3, plru, l2_complete,
      output resp_valid, resp_hit, resp_way, resp_victim_dirty, resp_victim_tag,
      output wb_req,
      input  wb_done
   );

   modport master (
      output req_valid, req_addr, req_write,
      input  req_ready,
      input  l2_block0_re, l2_block1_re, l2_block2_re, l2_block3_re,
      input  l2_block0_we, l2_block1_we, l2_block2_we, l2_block3_we,
      input  l2_index, l2_tag_wd, l2_dirty_wd,
      output l2_tag0_rd, l2_tag1_rd, l2_tag2_rd, l2_tag3_rd,
      output l2_dirty0, l2_dirty1, l2_dirty2, l2_dirty3, plru, l2_complete,
      input  resp_valid, resp_hit, resp_way, resp_victim_dirty, resp_victim_tag,
      input  wb_req,
      output wb_done
   );
endinterface

// File: rtl/l2_tag_ctrl.sv
// L2 tag lookup controller for a 4-way, 512-set tag RAM.
// Sequence: IDLE -> READ (all ways) -> CMP -> [WB_WAIT] -> WRITE -> RESP.
// Optional feature: define L2_VICTIM_WB_EN to stall on a dirty miss victim
// until the write-back agent answers wb_done; otherwise wb_req is tied low.
// All strobes and response fields are registered, decoded from next state.
module l2_tag_ctrl (
   input  logic          clk,
   input  logic          rst,
   l2_tag_ctrl_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      READ    = 3'd1,
      CMP     = 3'd2,
      WB_WAIT = 3'd3,
      WRITE   = 3'd4,
      RESP    = 3'd5
   } state_t;

   function automatic logic [3:0] way_onehot(input logic [1:0] way);
      way_onehot = 4'b0001 << way;
   endfunction

   state_t      state_q, state_d;
   logic [17:0] tag_q;
   logic [8:0]  index_q;
   logic        write_q;
   logic [1:0]  way_q, way_d;
   logic        hit_q;
   logic        old_dirty_q;
   logic [17:0] old_tag_q;
   logic        dirty_wd_q;
   logic        re_q;
   logic [3:0]  we_q;
   logic        req_ready_q;
   logic        resp_valid_q;
   logic        resp_hit_q;
   logic [1:0]  resp_way_q;
   logic        resp_victim_dirty_q;
   logic [17:0] resp_victim_tag_q;

   logic [17:0] tag_rd_s [4];
   logic [3:0]  dirty_rd_s;
   logic [3:0]  hit_vec_s;
   logic        hit_s;
   logic [1:0]  hit_way_s;
   logic [1:0]  victim_s;
   logic [1:0]  sel_way_s;
   logic [17:0] sel_tag_s;
   logic        sel_dirty_s;
   logic [4:0]  unused_offset_s;

   assign tag_rd_s[0]     = bus.l2_tag0_rd;
   assign tag_rd_s[1]     = bus.l2_tag1_rd;
   assign tag_rd_s[2]     = bus.l2_tag2_rd;
   assign tag_rd_s[3]     = bus.l2_tag3_rd;
   assign dirty_rd_s      = {bus.l2_dirty3, bus.l2_dirty2, bus.l2_dirty1, bus.l2_dirty0};
   assign unused_offset_s = bus.req_addr[4:0];

   // Tag compare with lowest-way priority, PLRU victim and selected-way data.
   always_comb begin
      for (int w = 0; w < 4; w++) begin
         hit_vec_s[w] = (tag_rd_s[w] == tag_q);
      end
      hit_s = |hit_vec_s;
      if (hit_vec_s[0]) begin
         hit_way_s = 2'd0;
      end else if (hit_vec_s[1]) begin
         hit_way_s = 2'd1;
      end else if (hit_vec_s[2]) begin
         hit_way_s = 2'd2;
      end else begin
         hit_way_s = 2'd3;
      end
      if (bus.plru[0]) begin
         victim_s = bus.plru[2] ? 2'd3 : 2'd2;
      end else begin
         victim_s = bus.plru[1] ? 2'd1 : 2'd0;
      end
      sel_way_s   = hit_s ? hit_way_s : victim_s;
      sel_tag_s   = tag_rd_s[sel_way_s];
      sel_dirty_s = dirty_rd_s[sel_way_s];
      way_d       = (state_q == CMP) ? sel_way_s : way_q;
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               state_d = READ;
            end else begin
               state_d = IDLE;
            end
         end
         READ: state_d = CMP;
         CMP: begin
`ifdef L2_VICTIM_WB_EN
            if (!hit_s && sel_dirty_s) begin
               state_d = WB_WAIT;
            end else begin
               state_d = WRITE;
            end
`else
            state_d = WRITE;
`endif
         end
         WB_WAIT: begin
`ifdef L2_VICTIM_WB_EN
            if (bus.wb_done) begin
               state_d = WRITE;
            end else begin
               state_d = WB_WAIT;
            end
`else
            state_d = IDLE;
`endif
         end
         WRITE: begin
            if (bus.l2_complete) begin
               state_d = RESP;
            end else begin
               state_d = WRITE;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Latch tag, index and write flag when a request is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_q   <= 18'd0;
         index_q <= 9'd0;
         write_q <= 1'b0;
      end else if (state_q == IDLE && bus.req_valid) begin
         tag_q   <= bus.req_addr[31:14];
         index_q <= bus.req_addr[13:5];
         write_q <= bus.req_write;
      end
   end

   // Capture lookup result and the dirty bit to write back into the set.
   always_ff @(posedge clk) begin
      if (rst) begin
         way_q       <= 2'd0;
         hit_q       <= 1'b0;
         old_dirty_q <= 1'b0;
         old_tag_q   <= 18'd0;
         dirty_wd_q  <= 1'b0;
      end else if (state_q == CMP) begin
         way_q       <= sel_way_s;
         hit_q       <= hit_s;
         old_dirty_q <= sel_dirty_s;
         old_tag_q   <= sel_tag_s;
         dirty_wd_q  <= (hit_s & sel_dirty_s) | write_q;
      end
   end

   // Registered strobes, handshake and response, decoded from next state.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_ready_q         <= 1'b1;
         re_q                <= 1'b0;
         we_q                <= 4'b0000;
         resp_valid_q        <= 1'b0;
         resp_hit_q          <= 1'b0;
         resp_way_q          <= 2'd0;
         resp_victim_dirty_q <= 1'b0;
         resp_victim_tag_q   <= 18'd0;
      end else begin
         req_ready_q  <= (state_d == IDLE);
         re_q         <= (state_d == READ);
         we_q         <= (state_d == WRITE) ? way_onehot(way_d) : 4'b0000;
         resp_valid_q <= (state_d == RESP);
         if (state_d == RESP) begin
            resp_hit_q          <= hit_q;
            resp_way_q          <= way_q;
            resp_victim_dirty_q <= ~hit_q & old_dirty_q;
            resp_victim_tag_q   <= old_tag_q;
         end
      end
   end

`ifdef L2_VICTIM_WB_EN
   logic wb_req_q;

   // Write-back request follows WB_WAIT occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_req_q <= 1'b0;
      end else begin
         wb_req_q <= (state_d == WB_WAIT);
      end
   end

   assign bus.wb_req = wb_req_q;
`else
   logic unused_wb_done_s;
   assign unused_wb_done_s = bus.wb_done;
   assign bus.wb_req       = 1'b0;
`endif

   assign bus.req_ready         = req_ready_q;
   assign bus.l2_block0_re      = re_q;
   assign bus.l2_block1_re      = re_q;
   assign bus.l2_block2_re      = re_q;
   assign bus.l2_block3_re      = re_q;
   assign bus.l2_block0_we      = we_q[0];
   assign bus.l2_block1_we      = we_q[1];
   assign bus.l2_block2_we      = we_q[2];
   assign bus.l2_block3_we      = we_q[3];
   assign bus.l2_index          = index_q;
   assign bus.l2_tag_wd         = tag_q;
   assign bus.l2_dirty_wd       = dirty_wd_q;
   assign bus.resp_valid        = resp_valid_q;
   assign bus.resp_hit          = resp_hit_q;
   assign bus.resp_way          = resp_way_q;
   assign bus.resp_victim_dirty = resp_victim_dirty_q;
   assign bus.resp_victim_tag   = resp_victim_tag_q;

endmodule

// File: tb/tb_l2_tag_ctrl.sv
// Scoreboard bench for l2_tag_ctrl: a driver issues lookups against a
// per-transaction set image, a tag RAM / write-back model answers the
// strobes, and a monitor pops expected responses when resp_valid rises.
module tb_l2_tag_ctrl;

`ifdef L2_VICTIM_WB_EN
   localparam bit WB_EN = 1'b1;
`else
   localparam bit WB_EN = 1'b0;
`endif

   typedef struct {
      logic        hit;
      logic [1:0]  way;
      logic        vd;
      logic [17:0] vtag;
      logic [17:0] wtag;
      logic        wdirty;
      logic [8:0]  idx;
      int          lat;
      int          we_len;
      int          acc;
      int          reads;
      int          writes;
   } exp_t;

   logic clk;
   logic rst;
   l2_tag_ctrl_if bus ();

   l2_tag_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t sb_q[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;

   // driver-owned stimulus state
   logic [17:0] cur_tag [4];
   logic [3:0]  cur_dirty;
   logic [2:0]  cur_plru;
   int          cur_cdelay;
   int          cur_wbd;
   int          n_acc = 0;
   int          n_ok = 0;
   int          to_cnt = 0;
   bit          drv_done = 1'b0;

   // RAM-model-owned observations
   int          rd_cnt = 0;
   int          wr_cnt = 0;
   int          we_len = 0;
   logic [1:0]  wr_way;
   logic [17:0] wr_tag;
   logic        wr_dirty;
   logic [8:0]  wr_idx;
   logic [8:0]  rd_idx;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, want, cyc);
      end
   endtask

   // ---------------- tag RAM, completion and write-back model ----------------
   initial begin
      bit         hold;
      int         wb_cnt;
      logic [3:0] re_v;
      logic [3:0] we_v;
      hold = 1'b0;
      wb_cnt = 0;
      bus.l2_complete = 1'b0;
      bus.wb_done = 1'b0;
      bus.plru = 3'd0;
      bus.l2_tag0_rd = 18'd0; bus.l2_tag1_rd = 18'd0;
      bus.l2_tag2_rd = 18'd0; bus.l2_tag3_rd = 18'd0;
      bus.l2_dirty0 = 1'b0; bus.l2_dirty1 = 1'b0;
      bus.l2_dirty2 = 1'b0; bus.l2_dirty3 = 1'b0;
      wr_way = 2'd0; wr_tag = 18'd0; wr_dirty = 1'b0; wr_idx = 9'd0; rd_idx = 9'd0;
      forever begin
         @(negedge clk);
         re_v = {bus.l2_block3_re, bus.l2_block2_re, bus.l2_block1_re, bus.l2_block0_re};
         we_v = {bus.l2_block3_we, bus.l2_block2_we, bus.l2_block1_we, bus.l2_block0_we};
         if (re_v != 4'b0000) begin
            rd_cnt++;
            rd_idx = bus.l2_index;
            bus.l2_tag0_rd = cur_tag[0]; bus.l2_tag1_rd = cur_tag[1];
            bus.l2_tag2_rd = cur_tag[2]; bus.l2_tag3_rd = cur_tag[3];
            {bus.l2_dirty3, bus.l2_dirty2, bus.l2_dirty1, bus.l2_dirty0} = cur_dirty;
            bus.plru = cur_plru;
            hold = 1'b1;
            we_len = 0;
         end else if (hold) begin
            hold = 1'b0;
         end else begin
            bus.l2_tag0_rd = 18'($urandom); bus.l2_tag1_rd = 18'($urandom);
            bus.l2_tag2_rd = 18'($urandom); bus.l2_tag3_rd = 18'($urandom);
            {bus.l2_dirty3, bus.l2_dirty2, bus.l2_dirty1, bus.l2_dirty0} = 4'($urandom);
            bus.plru = 3'($urandom);
         end
         if (we_v != 4'b0000) begin
            we_len++;
            case (we_v)
               4'b0010: wr_way = 2'd1;
               4'b0100: wr_way = 2'd2;
               4'b1000: wr_way = 2'd3;
               default: wr_way = 2'd0;
            endcase
            wr_tag = bus.l2_tag_wd;
            wr_dirty = bus.l2_dirty_wd;
            wr_idx = bus.l2_index;
            if (we_len > cur_cdelay) begin
               bus.l2_complete = 1'b1;
               wr_cnt++;
            end else begin
               bus.l2_complete = 1'b0;
            end
         end else begin
            bus.l2_complete = 1'($urandom_range(0, 1));
         end
         if (bus.wb_req) begin
            bus.wb_done = (wb_cnt == cur_wbd);
            wb_cnt++;
         end else begin
            wb_cnt = 0;
            bus.wb_done = 1'($urandom_range(0, 1));
         end
      end
   end

   // ---------------- driver ----------------
   task automatic set_rand_set(input logic [17:0] avoid);
      for (int w = 0; w < 4; w++) begin
         cur_tag[w] = 18'($urandom);
         if (cur_tag[w] == avoid) cur_tag[w] = ~avoid;
      end
      cur_dirty  = 4'($urandom);
      cur_plru   = 3'($urandom);
      cur_cdelay = $urandom_range(0, 2);
      cur_wbd    = $urandom_range(0, 3);
   endtask

   task automatic wait_ready();
      int k;
      k = 0;
      while (!bus.req_ready && k < 80) begin
         @(negedge clk);
         k++;
      end
      if (!bus.req_ready) to_cnt++;
   endtask

   task automatic run_txn(input logic [31:0] addr, input logic wr, input bit abort);
      exp_t        e;
      logic [17:0] t;
      int          hw;
      int          sel;
      int          k;
      t  = addr[31:14];
      hw = -1;
      for (int w = 3; w >= 0; w--) if (cur_tag[w] == t) hw = w;
      if (hw >= 0) sel = hw;
      else if (cur_plru[0]) sel = 2 + int'(cur_plru[2]);
      else sel = int'(cur_plru[1]);
      e.hit    = (hw >= 0);
      e.way    = 2'(sel);
      e.vd     = !e.hit && cur_dirty[sel];
      e.vtag   = cur_tag[sel];
      e.wtag   = t;
      e.wdirty = (e.hit && cur_dirty[sel]) || wr;
      e.idx    = addr[13:5];
      e.we_len = cur_cdelay + 1;
      e.lat    = 4 + cur_cdelay + ((WB_EN && e.vd) ? cur_wbd + 1 : 0);
      if (abort) cur_cdelay = 7;
      @(negedge clk);
      bus.req_addr  = addr;
      bus.req_write = wr;
      bus.req_valid = 1'b1;
      wait_ready();
      e.acc = cyc;
      n_acc++;
      e.reads = n_acc;
      if (!abort) begin
         n_ok++;
         e.writes = n_ok;
         sb_q.push_back(e);
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_addr  = $urandom;
      bus.req_write = 1'($urandom);
      if (abort) begin
         k = 0;
         while ({bus.l2_block3_we, bus.l2_block2_we, bus.l2_block1_we, bus.l2_block0_we} == 4'b0000 && k < 20) begin
            @(negedge clk);
            k++;
         end
         if (k >= 20) to_cnt++;
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
      end
      wait_ready();
   endtask

   initial begin
      logic [31:0] a;
      int          w;
      rst = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_addr = 32'd0;
      bus.req_write = 1'b0;
      set_rand_set(18'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      // hit in way2, dirty bit preserved on a read
      set_rand_set(18'h2A5A5); cur_tag[2] = 18'h2A5A5; cur_cdelay = 0;
      run_txn({18'h2A5A5, 9'h1F3, 5'h00}, 1'b0, 1'b0);
      // miss, plru=001 -> way2 clean victim, write access
      set_rand_set(18'h01234); cur_plru = 3'b001; cur_dirty[2] = 1'b0; cur_cdelay = 0;
      run_txn({18'h01234, 9'h0AA, 5'h03}, 1'b1, 1'b0);
      // miss, plru=000 -> way0 dirty victim, write-back answered after 3 cycles
      set_rand_set(18'h3FFFF); cur_plru = 3'b000; cur_dirty[0] = 1'b1; cur_wbd = 3; cur_cdelay = 0;
      run_txn({18'h3FFFF, 9'h155, 5'h00}, 1'b0, 1'b0);
      // duplicate tag in ways 1 and 3 resolves to way1
      set_rand_set(18'h12345); cur_tag[1] = 18'h12345; cur_tag[3] = 18'h12345;
      run_txn({18'h12345, 9'h001, 5'h10}, 1'b1, 1'b0);
      // completion one and two cycles late
      set_rand_set(18'h00F0F); cur_tag[0] = 18'h00F0F; cur_cdelay = 1;
      run_txn({18'h00F0F, 9'h1FF, 5'h00}, 1'b0, 1'b0);
      set_rand_set(18'h00F0F); cur_tag[3] = 18'h00F0F; cur_cdelay = 2;
      run_txn({18'h00F0F, 9'h000, 5'h00}, 1'b1, 1'b0);
      // reset during WRITE aborts the request
      set_rand_set(18'h0BEEF); cur_tag[1] = 18'h0BEEF;
      run_txn({18'h0BEEF, 9'h0C3, 5'h00}, 1'b0, 1'b1);
      set_rand_set(18'h0BEEF);
      run_txn({18'h0BEEF, 9'h0C3, 5'h00}, 1'b1, 1'b0);
      // randomized traffic
      for (int i = 0; i < 200; i++) begin
         a = $urandom;
         set_rand_set(a[31:14]);
         if ($urandom_range(0, 1) == 1) begin
            w = $urandom_range(0, 3);
            cur_tag[w] = a[31:14];
            if ($urandom_range(0, 3) == 0) cur_tag[$urandom_range(0, 3)] = a[31:14];
         end
         repeat ($urandom_range(0, 2)) @(negedge clk);
         run_txn(a, 1'($urandom), ($urandom_range(0, 15) == 0));
      end
      repeat (5) @(negedge clk);
      drv_done = 1'b1;
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin
      exp_t        e;
      bit          rst_prev;
      int          ncyc;
      logic [3:0]  re_v;
      logic [3:0]  we_v;
      logic        proto_ok;
      logic        l_hit;
      logic [1:0]  l_way;
      logic        l_vd;
      logic [17:0] l_vtag;
      rst_prev = 1'b0;
      ncyc = 0;
      l_hit = 1'b0; l_way = 2'd0; l_vd = 1'b0; l_vtag = 18'd0;
      forever begin
         @(negedge clk);
         #1;
         ncyc++;
         re_v = {bus.l2_block3_re, bus.l2_block2_re, bus.l2_block1_re, bus.l2_block0_re};
         we_v = {bus.l2_block3_we, bus.l2_block2_we, bus.l2_block1_we, bus.l2_block0_we};
         if (rst_prev) begin
            chk("reset_outputs",
                64'({bus.req_ready, re_v, we_v, bus.wb_req, bus.resp_valid, bus.resp_hit,
                     bus.resp_way, bus.resp_victim_dirty, bus.resp_victim_tag,
                     bus.l2_index, bus.l2_tag_wd, bus.l2_dirty_wd}),
                64'h1000_0000_0000_0000);
            l_hit = 1'b0; l_way = 2'd0; l_vd = 1'b0; l_vtag = 18'd0;
         end else begin
            proto_ok = ($countones(we_v) <= 1) && !((re_v != 4'b0000) && (we_v != 4'b0000)) &&
                       (re_v == 4'b0000 || re_v == 4'b1111) && (WB_EN || !bus.wb_req);
            chk("strobe_protocol", 64'(proto_ok), 64'd1);
            if (bus.resp_valid) begin
               chk("resp_expected", 64'(sb_q.size() != 0), 64'd1);
               if (sb_q.size() != 0) begin
                  e = sb_q.pop_front();
                  chk("resp_hit", 64'(bus.resp_hit), 64'(e.hit));
                  chk("resp_way", 64'(bus.resp_way), 64'(e.way));
                  chk("resp_victim_dirty", 64'(bus.resp_victim_dirty), 64'(e.vd));
                  chk("resp_victim_tag", 64'(bus.resp_victim_tag), 64'(e.vtag));
                  chk("latency", 64'(cyc - e.acc), 64'(e.lat));
                  chk("read_index", 64'(rd_idx), 64'(e.idx));
                  chk("write_index", 64'(wr_idx), 64'(e.idx));
                  chk("write_way", 64'(wr_way), 64'(e.way));
                  chk("write_tag", 64'(wr_tag), 64'(e.wtag));
                  chk("write_dirty", 64'(wr_dirty), 64'(e.wdirty));
                  chk("we_cycles", 64'(we_len), 64'(e.we_len));
                  chk("read_count", 64'(rd_cnt), 64'(e.reads));
                  chk("write_count", 64'(wr_cnt), 64'(e.writes));
                  l_hit = e.hit; l_way = e.way; l_vd = e.vd; l_vtag = e.vtag;
               end
            end else begin
               chk("resp_hold",
                   64'({bus.resp_hit, bus.resp_way, bus.resp_victim_dirty, bus.resp_victim_tag}),
                   64'({l_hit, l_way, l_vd, l_vtag}));
            end
         end
         rst_prev = rst;
         if (drv_done) begin
            chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
            chk("driver_timeouts", 64'(to_cnt), 64'd0);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
         end
         if (ncyc > 40000) begin
            total++;
            bad++;
            $display("FAIL watchdog: got %0d cycles expected at most 40000", ncyc);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
         end
      end
   end

endmodule
